mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-master to one-slave memory bus arbiter. Round-robin on
//             ties, a single outstanding transfer, a slave-wait timeout that
//             completes the transfer with all-ones read data, and abort of a
//             transfer whose master withdraws its request.
//  Ports    : clk, reset               - clock, synchronous active-high reset
//             mN_valid/addr/wdata/wstrb - master N request (wstrb 0 = read)
//             mN_ready/rdata            - master N completion, rdata 0 unless ready
//             s_valid/addr/wdata/wstrb  - shared slave request
//             s_ready/rdata             - OR-combined slave response
//             grant                     - one-hot owner (bit0 m0, bit1 m1)
//             timeout                   - pulse on a timed-out completion
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Last BUSY cycle a transfer may wait before it is forced to complete.
    localparam logic [15:0] C_WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q,   state_d;
    logic [1:0]  grant_q,   grant_d;
    logic        last_m1_q, last_m1_d;   // 1: m1 was served last
    logic [15:0] wait_q,    wait_d;

    logic        w_sel_valid;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic        w_drive;                // slave request is presented
    logic        w_done;                 // granted master completes this cycle
    logic [31:0] w_done_rdata;
    logic        w_timeout;
    logic        w_live;

    // The owner's request is routed straight through while BUSY.
    assign w_sel_valid = grant_q[1] ? m1_valid : m0_valid;
    assign w_sel_addr  = grant_q[1] ? m1_addr  : m0_addr;
    assign w_sel_wdata = grant_q[1] ? m1_wdata : m0_wdata;
    assign w_sel_wstrb = grant_q[1] ? m1_wstrb : m0_wstrb;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_m1_d    = last_m1_q;
        wait_d       = wait_q;
        w_drive      = 1'b0;
        w_done       = 1'b0;
        w_done_rdata = '0;
        w_timeout    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d  = '0;
                grant_d = 2'b00;
                if (m0_valid && m1_valid) begin
                    grant_d = last_m1_q ? 2'b01 : 2'b10;
                    state_d = ST_BUSY;
                end else if (m0_valid) begin
                    grant_d = 2'b01;
                    state_d = ST_BUSY;
                end else if (m1_valid) begin
                    grant_d = 2'b10;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_sel_valid) begin
                    // Withdrawn request: drop the slave request, no ready,
                    // round-robin history untouched.
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (s_ready) begin
                    // Slave response wins even on the timeout cycle.
                    w_drive      = 1'b1;
                    w_done       = 1'b1;
                    w_done_rdata = s_rdata;
                end else if (wait_q == C_WAIT_LAST) begin
                    w_done       = 1'b1;
                    w_done_rdata = 32'hFFFF_FFFF;
                    w_timeout    = 1'b1;
                end else begin
                    w_drive = 1'b1;
                    wait_d  = wait_q + 16'd1;
                end
                if (w_done) begin
                    last_m1_d = grant_q[1];
                    state_d   = ST_IDLE;
                    grant_d   = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            last_m1_q <= 1'b1;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_m1_q <= last_m1_d;
            wait_q    <= wait_d;
        end
    end

    // While reset is asserted every output is forced low, even if a transfer
    // was in flight, so an aborted transfer never produces a ready.
    assign w_live   = !reset;

    assign s_valid  = w_live && w_drive;
    assign s_addr   = s_valid ? w_sel_addr  : '0;
    assign s_wdata  = s_valid ? w_sel_wdata : '0;
    assign s_wstrb  = s_valid ? w_sel_wstrb : '0;

    assign m0_ready = w_live && w_done && grant_q[0];
    assign m1_ready = w_live && w_done && grant_q[1];
    assign m0_rdata = m0_ready ? w_done_rdata : '0;
    assign m1_rdata = m1_ready ? w_done_rdata : '0;

    assign grant    = w_live ? grant_q : 2'b00;
    assign timeout  = w_live && w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench for mem_bus_arbiter: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a transaction-level model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .timeout  (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: who owns the bus (-1 none, 0 m0, 1 m1),
    // how many cycles the owner has been waiting, who was served last.
    // ------------------------------------------------------------------
    int           m_own  = -1;
    int           m_age  = 0;
    int           m_last = 1;
    bit           m_on   = 1'b0;
    logic [137:0] m_exp, m_act;

    always @(negedge clk) begin : model
        logic [1:0]  e_grant;
        logic        e_to, e_sv, e_r0, e_r1, mv;
        logic [31:0] e_sa, e_sw, e_d0, e_d1, fin_data;
        logic [3:0]  e_ss;
        int          n_own, n_age, n_last;
        bit          fin;

        e_grant = 2'b00; e_to = 1'b0; e_sv = 1'b0;
        e_sa = '0; e_sw = '0; e_ss = '0;
        e_r0 = 1'b0; e_r1 = 1'b0; e_d0 = '0; e_d1 = '0;
        n_own = m_own; n_age = m_age; n_last = m_last;
        fin = 1'b0; fin_data = '0; mv = 1'b0;

        if (reset) begin
            m_on   = 1'b1;
            n_own  = -1;
            n_age  = 0;
            n_last = 1;
        end else if (m_own < 0) begin
            if (m0_valid && m1_valid) n_own = (m_last == 1) ? 0 : 1;
            else if (m0_valid)        n_own = 0;
            else if (m1_valid)        n_own = 1;
            n_age = 0;
        end else begin
            e_grant = (m_own == 0) ? 2'b01 : 2'b10;
            mv      = (m_own == 0) ? m0_valid : m1_valid;
            if (!mv) begin
                n_own = -1;
            end else begin
                if (s_ready) begin
                    e_sv     = 1'b1;
                    fin      = 1'b1;
                    fin_data = s_rdata;
                end else if (m_age == TO - 1) begin
                    fin      = 1'b1;
                    fin_data = 32'hFFFF_FFFF;
                    e_to     = 1'b1;
                end else begin
                    e_sv  = 1'b1;
                    n_age = m_age + 1;
                end
                if (e_sv) begin
                    e_sa = (m_own == 0) ? m0_addr  : m1_addr;
                    e_sw = (m_own == 0) ? m0_wdata : m1_wdata;
                    e_ss = (m_own == 0) ? m0_wstrb : m1_wstrb;
                end
                if (fin) begin
                    if (m_own == 0) begin e_r0 = 1'b1; e_d0 = fin_data; end
                    else            begin e_r1 = 1'b1; e_d1 = fin_data; end
                    n_last = m_own;
                    n_own  = -1;
                end
            end
        end

        m_exp = {e_grant, e_to, e_sv, e_sa, e_sw, e_ss, e_r0, e_d0, e_r1, e_d1};
        m_act = {grant, timeout, s_valid, s_addr, s_wdata, s_wstrb,
                 m0_ready, m0_rdata, m1_ready, m1_rdata};
        if (m_on) begin
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL model t=%0t {grant,to,sv,sa,sw,ss,r0,d0,r1,d1} dut=%h model=%h",
                         $time, m_act, m_exp);
            end
        end
        m_own  = n_own;
        m_age  = n_age;
        m_last = n_last;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
    endtask

    // Returns in the first cycle after reset release (bus idle).
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        chk("rst_grant",   32'(grant),    32'h0);
        chk("rst_svalid",  32'(s_valid),  32'h0);
        chk("rst_timeout", 32'(timeout),  32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(grant), 32'h0);

        // Single zero-wait read from m0.
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0010_0000; m0_wstrb = 4'h0;
        @(negedge clk);
        chk("rd_arb_grant", 32'(grant),    32'h0);
        chk("rd_arb_ready", 32'(m0_ready), 32'h0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_ready",  32'(m0_ready), 32'h1);
        chk("rd_rdata",  m0_rdata,      32'h1234_5678);
        chk("rd_grant",  32'(grant),    32'h1);
        chk("rd_saddr",  s_addr,        32'h0010_0000);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        @(negedge clk);
        chk("rd_after_grant", 32'(grant),    32'h0);
        chk("rd_after_ready", 32'(m0_ready), 32'h0);

        // Contention with a 1-wait slave: grants alternate m0, m1, m0, m1.
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_idle_grant", 32'(grant), 32'h0);
            tick();
            s_ready = 1'b0;
            @(negedge clk);
            chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k % 2 == 1) begin
                chk("rr_wdata", s_wdata,      32'hA5A5_A5A5);
                chk("rr_wstrb", 32'(s_wstrb), 32'hF);
            end
            tick();
            s_ready = 1'b1; s_rdata = 32'(k);
            @(negedge clk);
            chk("rr_ready", 32'({m1_ready, m0_ready}), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            s_ready = 1'b0;
        end

        // Timeout: m1 read, slave silent.
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0000_0300; m1_wstrb = 4'h0;
        tick();
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            if (c < TO) begin
                chk("to_wait_timeout", 32'(timeout),  32'h0);
                chk("to_wait_ready",   32'(m1_ready), 32'h0);
            end else begin
                chk("to_ready",   32'(m1_ready), 32'h1);
                chk("to_rdata",   m1_rdata,      32'hFFFF_FFFF);
                chk("to_pulse",   32'(timeout),  32'h1);
                chk("to_svalid",  32'(s_valid),  32'h0);
            end
            tick();
        end
        m1_valid = 1'b0;
        @(negedge clk);
        chk("to_idle_grant",   32'(grant),   32'h0);
        chk("to_idle_timeout", 32'(timeout), 32'h0);

        // Slave ready on the exact timeout cycle.
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0400; m0_wstrb = 4'h0;
        tick();
        repeat (TO - 1) tick();
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("co_ready",   32'(m0_ready), 32'h1);
        chk("co_rdata",   m0_rdata,      32'hCAFE_F00D);
        chk("co_timeout", 32'(timeout),  32'h0);
        chk("co_svalid",  32'(s_valid),  32'h1);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;

        // Reset during an m1 wait after m0 was served last.
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        tick();
        s_ready = 1'b1; s_rdata = 32'h0000_0055;
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0600;
        tick();
        tick();
        @(negedge clk);
        chk("rm_pre_grant", 32'(grant), 32'h2);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rm_grant",  32'(grant),    32'h0);
        chk("rm_svalid", 32'(s_valid),  32'h0);
        chk("rm_ready",  32'(m1_ready), 32'h0);
        tick();
        reset = 1'b0; m0_valid = 1'b1;
        @(negedge clk);
        chk("rm_rel_grant", 32'(grant),    32'h0);
        chk("rm_rel_ready", 32'(m1_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("rm_tie_grant", 32'(grant), 32'h1);
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();

        // Abort: m0 withdraws in its 2nd BUSY cycle, pending m1 goes next.
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0700;
        m1_valid = 1'b1; m1_addr = 32'h0000_0800;
        tick();
        @(negedge clk);
        chk("ab_grant0", 32'(grant), 32'h1);
        tick();
        m0_valid = 1'b0;
        @(negedge clk);
        chk("ab_svalid", 32'(s_valid),  32'h0);
        chk("ab_ready",  32'(m0_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("ab_idle_grant", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        chk("ab_grant1", 32'(grant), 32'h2);
        tick();
        m1_valid = 1'b0;
        tick();

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if (m0_valid) m0_valid = ($urandom_range(0, 15) != 0);
            else          m0_valid = ($urandom_range(0, 2) == 0);
            if (m1_valid) m1_valid = ($urandom_range(0, 15) != 0);
            else          m1_valid = ($urandom_range(0, 2) == 0);
            m0_addr  = $urandom;
            m0_wdata = $urandom;
            m0_wstrb = 4'($urandom_range(0, 15));
            m1_addr  = $urandom;
            m1_wdata = $urandom;
            m1_wstrb = 4'($urandom_range(0, 15));
            s_ready  = ($urandom_range(0, 3) == 0);
            s_rdata  = $urandom;
        end
        tick();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
